// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the MULTU/DIVU sequencer: ALU opcodes, op select and FSM states.
package muldiv_sequencer_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111
  } alu_op_t;

  localparam logic MD_OP_MULTU = 1'b0;
  localparam logic MD_OP_DIVU  = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } md_state_t;

endpackage

// File: rtl/muldiv_sequencer_alu.sv
// Core 32-bit ALU, reused by the sequencer as its only adder/subtractor.
// Purely combinational, zero latency; no flow control.
module muldiv_sequencer_alu
  import muldiv_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_SLT: y = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Unsigned MULTU/DIVU unit: 32 ALU iterations (done 32 cycles after accept), divide-by-zero short-cut.
// No queueing: start is taken only in IDLE/DONE; start while busy is dropped.
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int               WIDTH  = 32,
  parameter int               CNT_W  = 5,
  parameter logic [WIDTH-1:0] DBZ_LO = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             dbz
);

  md_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             op_r;
  // acc is P_hi (multiply) or R (divide); quo is P_lo or Q; opnd is M or D.
  logic [WIDTH-1:0] acc, quo, opnd;

  logic [WIDTH-1:0] alu_a, alu_b, alu_y;
  alu_op_t          alu_op;
  logic [WIDTH-1:0] acc_nxt, quo_nxt, rs, sum;
  logic             carry, brw, take, last;

  muldiv_sequencer_alu #(.WIDTH(WIDTH)) u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  always_comb begin
    rs     = {acc[WIDTH-2:0], quo[WIDTH-1]};
    alu_a  = '0;
    alu_b  = '0;
    alu_op = ALU_AND;
    if (state == RUN) begin
      alu_b = opnd;
      if (op_r == MD_OP_DIVU) begin
        alu_a  = rs;
        alu_op = ALU_SUB;
      end else begin
        alu_a  = acc;
        alu_op = ALU_ADD;
      end
    end

    sum   = quo[0] ? alu_y : acc;
    carry = quo[0] && (alu_y < acc);
    // A bit shifted out of R means the true partial remainder exceeds D: always subtract.
    brw   = alu_y > rs;
    take  = acc[WIDTH-1] | ~brw;

    if (op_r == MD_OP_DIVU) begin
      acc_nxt = take ? alu_y : rs;
      quo_nxt = {quo[WIDTH-2:0], take};
    end else begin
      acc_nxt = {carry, sum[WIDTH-1:1]};
      quo_nxt = {sum[0], quo[WIDTH-1:1]};
    end

    last = (cnt == {CNT_W{1'b1}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      op_r  <= 1'b0;
      acc   <= '0;
      quo   <= '0;
      opnd  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
      dbz   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          acc <= acc_nxt;
          quo <= quo_nxt;
          cnt <= cnt + 1'b1;
          if (last) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            hi    <= acc_nxt;
            lo    <= quo_nxt;
            dbz   <= 1'b0;
          end
        end
        default: begin
          if (start && op == MD_OP_DIVU && b == '0) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= a;
            lo    <= DBZ_LO;
            dbz   <= 1'b1;
          end else if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            cnt   <= '0;
            op_r  <= op;
            acc   <= '0;
            quo   <= (op == MD_OP_DIVU) ? a : b;
            opnd  <= (op == MD_OP_DIVU) ? b : a;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed vector table, multi-cycle corner sequences and a random scoreboard for muldiv_sequencer.
module tb_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbz;

  int n_cmp;
  int n_err;

  muldiv_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo),
    .dbz   (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one op; lat = edges after the accepting edge until done is seen (-1 on timeout).
  task automatic do_op(input logic op_i, input logic [31:0] a_i, input logic [31:0] b_i,
                       output int lat);
    @(negedge clk);
    start = 1'b1; op = op_i; a = a_i; b = b_i;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = done ? 0 : -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    int          seen;
    logic [63:0] prod;
    logic [31:0] ea, eb;
    logic        eop;

    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 1'b0;
    a     = '0;
    b     = '0;

    vecs[0] = '{1'b0, 32'd7,          32'd6,          32'd0,          32'd42,         1'b0};
    vecs[1] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'hFFFFFFFE,   32'h00000001,   1'b0};
    vecs[2] = '{1'b1, 32'd100,        32'd7,          32'd2,          32'd14,         1'b0};
    vecs[3] = '{1'b1, 32'hFFFFFFFF,   32'd1,          32'd0,          32'hFFFFFFFF,   1'b0};
    vecs[4] = '{1'b1, 32'h00001234,   32'd0,          32'h00001234,   32'hFFFFFFFF,   1'b1};
    vecs[5] = '{1'b0, 32'd3,          32'd3,          32'd0,          32'd9,          1'b0};
    vecs[6] = '{1'b1, 32'd5,          32'd10,         32'd5,          32'd0,          1'b0};
    vecs[7] = '{1'b1, 32'h80000000,   32'd3,          32'd2,          32'h2AAAAAAA,   1'b0};
    vecs[8] = '{1'b0, 32'h00010000,   32'h00010000,   32'd1,          32'd0,          1'b0};
    vecs[9] = '{1'b1, 32'h00000000,   32'd5,          32'd0,          32'd0,          1'b0};

    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_hi", hi, 0);
    check("rst_lo", lo, 0);
    check("rst_dbz", dbz, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
      check($sformatf("v%0d_dbz", i), dbz, vecs[i].dbz);
      if (vecs[i].dbz)
        check($sformatf("v%0d_lat_dbz", i), (lat >= 0 && lat <= 1), 1);
      else
        check($sformatf("v%0d_lat", i), 64'(lat), 64'd32);
      check($sformatf("v%0d_busy_in_done", i), busy, 0);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_pulse", i), done, 0);
      check($sformatf("v%0d_hold_lo", i), lo, vecs[i].lo);
    end

    // Start mid-run is ignored; start held in the DONE cycle is accepted back-to-back.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd123; b = 32'd456;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(negedge clk);
      if (n == 10) begin
        start = 1'b1; op = 1'b1; a = 32'd999; b = 32'd3;
      end
      @(posedge clk);
      #1;
      if (n == 10) start = 1'b0;
      if (n == 5) check("b2b_busy_mid", busy, 1);
      if (done) lat = n;
    end
    check("b2b_first_lat", 64'(lat), 64'd32);
    check("b2b_first_lo", lo, 32'd56088);
    check("b2b_first_hi", hi, 32'd0);
    start = 1'b1; op = 1'b1; a = 32'd100; b = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    check("b2b_second_busy", busy, 1);
    lat = done ? 0 : -1;
    for (int n = 1; n <= 100 && lat < 0; n++) begin
      @(posedge clk);
      #1;
      if (done) lat = n;
    end
    check("b2b_second_lat", 64'(lat), 64'd32);
    check("b2b_second_lo", lo, 32'd14);
    check("b2b_second_hi", hi, 32'd2);

    // Reset in the middle of a run aborts it with no done pulse.
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 32'd5; b = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_hi", hi, 0);
    check("midrst_lo", lo, 0);
    check("midrst_dbz", dbz, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    check("midrst_no_done", 64'(seen), 64'd0);
    do_op(1'b0, 32'd5, 32'd5, lat);
    check("midrst_fresh_lo", lo, 32'd25);
    check("midrst_fresh_lat", 64'(lat), 64'd32);

    // Random scoreboard against behavioural multiply/divide.
    for (int i = 0; i < 500; i++) begin
      eop = 1'($urandom_range(0, 1));
      ea  = $urandom;
      eb  = $urandom;
      if ($urandom_range(0, 3) == 0) eb = 32'($urandom_range(0, 15));
      do_op(eop, ea, eb, lat);
      if (eop == 1'b0) begin
        prod = {32'd0, ea} * {32'd0, eb};
        check("rnd_mul_hi", hi, prod[63:32]);
        check("rnd_mul_lo", lo, prod[31:0]);
        check("rnd_mul_dbz", dbz, 0);
      end else if (eb == 32'd0) begin
        check("rnd_dbz_hi", hi, ea);
        check("rnd_dbz_lo", lo, 32'hFFFFFFFF);
        check("rnd_dbz_flag", dbz, 1);
      end else begin
        check("rnd_div_hi", hi, ea % eb);
        check("rnd_div_lo", lo, ea / eb);
        check("rnd_div_dbz", dbz, 0);
      end
      if (lat < 0) check("rnd_timeout", 64'(lat), 64'd32);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
